// File: rtl/spectrum_bar_shaper_if.sv
// Bundle of frame handshake and bin data exchanged between the spectrum
// source, the bar shaper and the bar renderer.
interface spectrum_bar_shaper_if;
    logic         start;
    logic [287:0] samples;
    logic [287:0] bars;
    logic         busy;
    logic         done;

    modport master (
        output start,
        output samples,
        input  bars,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  samples,
        output bars,
        output busy,
        output done
    );
endinterface

// File: rtl/spectrum_bar_shaper.sv
// Captures 16 spectrum bins per frame, scales/saturates each to a bar height
// with peak-hold and linear decay, and publishes all heights atomically.
module spectrum_bar_shaper #(
    parameter int SHIFT       = 6,
    parameter int MAX_HEIGHT  = 480,
    parameter int HOLD_FRAMES = 8,
    parameter int DECAY       = 8
) (
    input  logic                  clk_25,
    input  logic                  rst,
    spectrum_bar_shaper_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROC   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [3:0]     r_idx;
    logic [287:0]   r_shadow;
    logic [8:0]     r_held     [16];
    logic [3:0]     r_hold_cnt [16];
    logic [287:0]   r_bars;
    logic           r_busy;
    logic           r_done;

    logic [8:0]     w_base;
    logic [17:0]    w_raw;
    logic [8:0]     w_h;
    logic [8:0]     w_held_cur;
    logic [3:0]     w_cnt_cur;
    logic [8:0]     w_held_new;
    logic [3:0]     w_cnt_new;

    function automatic logic [8:0] scale_sat(input logic [17:0] raw);
        logic [17:0] s;
        s = raw >> SHIFT;
        if (s > 18'(MAX_HEIGHT)) begin
            return 9'(MAX_HEIGHT);
        end else begin
            return s[8:0];
        end
    endfunction

    // Decay never drops below the live height and never wraps below zero.
    function automatic logic [8:0] decay_floor(input logic [8:0] held, input logic [8:0] h);
        logic [8:0] d;
        if (held > 9'(DECAY)) begin
            d = held - 9'(DECAY);
        end else begin
            d = 9'd0;
        end
        if (d > h) begin
            return d;
        end else begin
            return h;
        end
    endfunction

    assign w_base     = 9'(r_idx) * 9'd18;
    assign w_raw      = r_shadow[w_base +: 18];
    assign w_h        = scale_sat(w_raw);
    assign w_held_cur = r_held[r_idx];
    assign w_cnt_cur  = r_hold_cnt[r_idx];

    // Peak-hold update for the bin currently selected by r_idx.
    always_comb begin
        w_held_new = w_held_cur;
        w_cnt_new  = w_cnt_cur;
        if (w_h >= w_held_cur) begin
            w_held_new = w_h;
            w_cnt_new  = 4'd0;
        end else if (w_cnt_cur < 4'(HOLD_FRAMES)) begin
            w_cnt_new  = w_cnt_cur + 4'd1;
        end else begin
            w_held_new = decay_floor(w_held_cur, w_h);
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_PROC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_PROC: begin
                if (r_idx == 4'd15) begin
                    w_state_next = ST_COMMIT;
                end else begin
                    w_state_next = ST_PROC;
                end
            end
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture, per-bin processing, atomic publish and status outputs.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            r_idx    <= 4'd0;
            r_shadow <= 288'd0;
            r_bars   <= 288'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_held[i]     <= 9'd0;
                r_hold_cnt[i] <= 4'd0;
            end
        end else begin
            r_busy <= (w_state_next == ST_PROC) || (w_state_next == ST_COMMIT);
            r_done <= (r_state == ST_COMMIT);
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_shadow <= bus.samples;
                        r_idx    <= 4'd0;
                    end
                end
                ST_PROC: begin
                    r_held[r_idx]     <= w_held_new;
                    r_hold_cnt[r_idx] <= w_cnt_new;
                    r_idx             <= r_idx + 4'd1;
                end
                ST_COMMIT: begin
                    for (int i = 0; i < 16; i++) begin
                        r_bars[i*18 +: 18] <= {9'd0, r_held[i]};
                    end
                end
                default: r_idx <= 4'd0;
            endcase
        end
    end

    assign bus.bars = r_bars;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
